// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick helper for the FIFO port arbiters.
package fifo_arb_pkg;

    localparam int unsigned DATA_W_DEF = 128;
    localparam int unsigned MAX_REQ    = 32;
    localparam int unsigned IDX_MAX_W  = 5;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [IDX_MAX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid[num_req-1:0] searching from ptr+1 upward, wrapping.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input int unsigned        ptr,
                                         input int unsigned        num_req);
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned off = 1; off <= num_req; off++) begin
            cand = ptr + off;
            if (cand >= num_req) begin
                cand = cand - num_req;
            end
            if (!res.found && valid[IDX_MAX_W'(cand)]) begin
                res.found = 1'b1;
                res.idx   = IDX_MAX_W'(cand);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority pick: lowest valid index after ptr wins.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [MAX_REQ-1:0] valid_ext;
    rr_pick_t           pick;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = valid;
        pick                     = rr_pick(valid_ext, 32'(ptr), NUM_REQ);
    end

    assign found = pick.found;
    assign idx   = IDX_W'(pick.idx);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing the write FIFO port between requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned DATA_W    = DATA_W_DEF,
    parameter  int unsigned CNT_W     = 256,
    parameter  int unsigned DEPTH     = 16,
    parameter  int unsigned MAX_BURST = 4,
    localparam int unsigned IDX_W     = $clog2(NUM_REQ),
    localparam int unsigned BEAT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wr,
    output logic [DATA_W-1:0]         D_in,
    input  logic                      full,
    input  logic [CNT_W-1:0]          fifo_cnt,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy
);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic              busy_q, busy_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [CNT_W:0]    cnt_plus_burst;
    logic              room;

    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .valid(req_valid),
        .ptr  (rr_ptr_q),
        .found(pick_found),
        .idx  (pick_idx)
    );

    // One extra bit so a near-saturated fifo_cnt cannot wrap into "room".
    assign cnt_plus_burst = {1'b0, fifo_cnt} + (CNT_W+1)'(MAX_BURST);
    assign room           = cnt_plus_burst <= (CNT_W+1)'(DEPTH);

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IDX_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        req_ready  = '0;
        wr         = 1'b0;
        D_in       = '0;

        case (state_q)
            IDLE: begin
                if (pick_found && room) begin
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = BURST;
                end
            end
            BURST: begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (grant_id_q == IDX_W'(i)) && !full;
                end
                wr   = g_valid && !full;
                D_in = g_data;
                if (wr) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (g_last || (beat_cnt_q == BEAT_W'(MAX_BURST - 1))) begin
                        rr_ptr_d   = grant_id_q;
                        beat_cnt_d = '0;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenarios plus a randomized run checked against a rule-level model.
module tb_fifo_wr_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 128;
    localparam int CW  = 256;
    localparam int DEP = 16;
    localparam int MB  = 4;

    logic             clock = 1'b0;
    logic             rst   = 1'b0;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             wr;
    logic [DW-1:0]    D_in;
    logic             full;
    logic [CW-1:0]    fifo_cnt;
    logic [1:0]       grant_id;
    logic             busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fifo_wr_arbiter #(
        .NUM_REQ  (NR),
        .DATA_W   (DW),
        .CNT_W    (CW),
        .DEPTH    (DEP),
        .MAX_BURST(MB)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .wr       (wr),
        .D_in     (D_in),
        .full     (full),
        .fifo_cnt (fifo_cnt),
        .grant_id (grant_id),
        .busy     (busy)
    );

    function automatic logic [DW-1:0] mkdata(int r, int s);
        return {32'(r), 32'(s), 32'hC0DE_0000 ^ 32'(s * 7), 32'hA5A5_5A5A ^ 32'(r)};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        full      = 1'b0;
        fifo_cnt  = '0;
    endtask

    task automatic set_data(int r, logic [DW-1:0] d);
        req_data[r*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_valid = '1;
        req_last  = '1;
        for (int r = 0; r < NR; r++) set_data(r, mkdata(r, 9));
        full     = 1'b0;
        fifo_cnt = '0;
        #3;
        for (int k = 0; k < 2; k++) begin
            total++; if (wr !== 1'b0) begin bad++; $display("FAIL reset_wr: got %0b want 0", wr); end
            total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
            total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
            total++; if (D_in !== '0) begin bad++; $display("FAIL reset_din: got %h want 0", D_in); end
            cyc();
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] d [3];
        do_reset();
        for (int k = 0; k < 3; k++) d[k] = mkdata(1, 10 + k);
        req_valid = 4'b0010;
        set_data(1, d[0]);
        #1;
        total++; if (wr !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle: got wr=%0b busy=%0b want 0 0", wr, busy); end
        cyc();
        for (int k = 0; k < 3; k++) begin
            set_data(1, d[k]);
            req_last = (k == 2) ? 4'b0010 : 4'b0000;
            #1;
            total++; if (wr !== 1'b1) begin bad++; $display("FAIL single_wr%0d: got %0b want 1", k, wr); end
            total++; if (D_in !== d[k]) begin bad++; $display("FAIL single_din%0d: got %h want %h", k, D_in, d[k]); end
            total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL single_grant%0d: got %0d want 1", k, grant_id); end
            total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready%0d: got %b want 0010", k, req_ready); end
            cyc();
        end
        req_valid = '0;
        req_last  = '0;
        #1;
        total++; if (busy !== 1'b0 || wr !== 1'b0) begin bad++; $display("FAIL single_end: got busy=%0b wr=%0b want 0 0", busy, wr); end
        total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL single_end_grant: got %0d want 1", grant_id); end
    endtask

    task automatic test_round_robin();
        int exp;
        do_reset();
        req_valid = '1;
        req_last  = '1;
        for (int r = 0; r < NR; r++) set_data(r, mkdata(r, 100));
        for (int n = 0; n < 5; n++) begin
            exp = n % NR;
            #1;
            total++; if (busy !== 1'b0 || wr !== 1'b0) begin bad++; $display("FAIL rr_idle%0d: got busy=%0b wr=%0b want 0 0", n, busy, wr); end
            cyc();
            total++; if (wr !== 1'b1 || grant_id !== 2'(exp)) begin bad++; $display("FAIL rr_grant%0d: got wr=%0b id=%0d want 1 %0d", n, wr, grant_id, exp); end
            total++; if (D_in !== mkdata(exp, 100)) begin bad++; $display("FAIL rr_din%0d: got %h want %h", n, D_in, mkdata(exp, 100)); end
            cyc();
        end
    endtask

    task automatic test_burst_cap();
        do_reset();
        req_valid = 4'b0100;
        set_data(2, mkdata(2, 0));
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cap_idle: got %0b want 0", busy); end
        cyc();
        for (int k = 0; k < 6; k++) begin
            set_data(2, mkdata(2, k));
            if (k == 4) begin
                #1;
                total++; if (busy !== 1'b0 || wr !== 1'b0) begin bad++; $display("FAIL cap_release: got busy=%0b wr=%0b want 0 0", busy, wr); end
                cyc();
            end
            #1;
            total++; if (wr !== 1'b1 || grant_id !== 2'd2) begin bad++; $display("FAIL cap_beat%0d: got wr=%0b id=%0d want 1 2", k, wr, grant_id); end
            total++; if (D_in !== mkdata(2, k)) begin bad++; $display("FAIL cap_din%0d: got %h want %h", k, D_in, mkdata(2, k)); end
            cyc();
        end
        req_valid = '0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (busy !== 1'b1 || wr !== 1'b0 || grant_id !== 2'd2) begin bad++; $display("FAIL cap_hold%0d: got busy=%0b wr=%0b id=%0d want 1 0 2", k, busy, wr, grant_id); end
            cyc();
        end
    endtask

    task automatic test_room();
        do_reset();
        req_valid = 4'b0001;
        set_data(0, mkdata(0, 5));
        fifo_cnt = '1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (busy !== 1'b0 || wr !== 1'b0) begin bad++; $display("FAIL room_wrap%0d: got busy=%0b wr=%0b want 0 0", c, busy, wr); end
            cyc();
        end
        fifo_cnt = CW'(13);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (busy !== 1'b0 || wr !== 1'b0) begin bad++; $display("FAIL room_13_%0d: got busy=%0b wr=%0b want 0 0", c, busy, wr); end
            cyc();
        end
        fifo_cnt = CW'(12);
        cyc();
        total++; if (busy !== 1'b1 || grant_id !== 2'd0 || wr !== 1'b1) begin bad++; $display("FAIL room_12: got busy=%0b id=%0d wr=%0b want 1 0 1", busy, grant_id, wr); end
    endtask

    task automatic test_stall();
        bit            sv [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bit            sf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [DW-1:0] d [4];
        logic [DW-1:0] got [$];
        logic          exp_wr;
        int            idx;
        do_reset();
        for (int k = 0; k < 4; k++) d[k] = mkdata(3, 40 + k);
        req_valid = 4'b1000;
        set_data(3, d[0]);
        cyc();
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            req_valid = sv[c] ? 4'b1000 : 4'b0000;
            full      = sf[c];
            set_data(3, d[idx]);
            req_last  = (idx == 3) ? 4'b1000 : 4'b0000;
            #1;
            exp_wr = sv[c] && !sf[c];
            total++; if (wr !== exp_wr) begin bad++; $display("FAIL stall_wr%0d: got %0b want %0b", c, wr, exp_wr); end
            total++; if (busy !== 1'b1 || grant_id !== 2'd3) begin bad++; $display("FAIL stall_hold%0d: got busy=%0b id=%0d want 1 3", c, busy, grant_id); end
            total++; if (req_ready !== (sf[c] ? 4'b0000 : 4'b1000)) begin bad++; $display("FAIL stall_ready%0d: got %b want %b", c, req_ready, sf[c] ? 4'b0000 : 4'b1000); end
            if (wr === 1'b1) got.push_back(D_in);
            if (exp_wr) idx++;
            cyc();
        end
        req_valid = '0;
        req_last  = '0;
        full      = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_end: got busy=%0b want 0", busy); end
        total++; if (got.size() != 4) begin bad++; $display("FAIL stall_count: got %0d beats want 4", got.size()); end
        for (int k = 0; k < 4; k++) begin
            total++; if (k >= got.size() || got[k] !== d[k]) begin bad++; $display("FAIL stall_order%0d: got %h want %h", k, (k < got.size()) ? got[k] : '0, d[k]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0100;
        req_last  = 4'b0100;
        set_data(2, mkdata(2, 60));
        cyc();
        total++; if (wr !== 1'b1 || grant_id !== 2'd2) begin bad++; $display("FAIL rmid_pre: got wr=%0b id=%0d want 1 2", wr, grant_id); end
        cyc();
        req_valid = 4'b0010;
        req_last  = '0;
        cyc();
        for (int k = 0; k < 2; k++) begin
            set_data(1, mkdata(1, 70 + k));
            #1;
            total++; if (wr !== 1'b1 || D_in !== mkdata(1, 70 + k)) begin bad++; $display("FAIL rmid_beat%0d: got wr=%0b din=%h", k, wr, D_in); end
            cyc();
        end
        set_data(1, mkdata(1, 72));
        #2;
        rst = 1'b0;
        #1;
        total++; if (wr !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_async: got wr=%0b ready=%b busy=%0b want 0 0000 0", wr, req_ready, busy); end
        total++; if (D_in !== '0) begin bad++; $display("FAIL rmid_din: got %h want 0", D_in); end
        cyc();
        total++; if (wr !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_held: got wr=%0b busy=%0b want 0 0", wr, busy); end
        rst       = 1'b1;
        req_valid = '1;
        req_last  = '1;
        for (int r = 0; r < NR; r++) set_data(r, mkdata(r, 80));
        cyc();
        total++; if (busy !== 1'b1 || grant_id !== 2'd0 || D_in !== mkdata(0, 80)) begin bad++; $display("FAIL rmid_first: got busy=%0b id=%0d want 1 0", busy, grant_id); end
    endtask

    task automatic test_random();
        int            owner, beats, rr, gid, cnt;
        int            seq [NR];
        bit            cl  [NR];
        bit            vld [NR];
        bit            fl, found, any;
        logic [NR-1:0] exp_ready;
        logic          exp_wr;
        do_reset();
        owner = -1; beats = 0; rr = NR - 1; gid = 0;
        for (int r = 0; r < NR; r++) begin
            seq[r] = 0;
            cl[r]  = ($urandom_range(0, 2) == 0);
        end
        for (int c = 0; c < 1500; c++) begin
            any = 1'b0;
            for (int r = 0; r < NR; r++) begin
                vld[r]       = ($urandom_range(0, 3) != 0);
                any          = any | vld[r];
                req_valid[r] = vld[r];
                req_last[r]  = cl[r];
                set_data(r, mkdata(r, seq[r]));
            end
            fl       = ($urandom_range(0, 9) == 0);
            full     = fl;
            cnt      = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, DEP));
            fifo_cnt = CW'(cnt);
            #1;
            exp_ready = (owner >= 0 && !fl) ? (NR'(1) << owner) : '0;
            exp_wr    = (owner >= 0) && vld[owner] && !fl;
            total++; if (busy !== (owner >= 0)) begin bad++; $display("FAIL rand_busy c%0d: got %0b want %0b", c, busy, owner >= 0); end
            total++; if (grant_id !== 2'(gid)) begin bad++; $display("FAIL rand_grant c%0d: got %0d want %0d", c, grant_id, gid); end
            total++; if (wr !== exp_wr) begin bad++; $display("FAIL rand_wr c%0d: got %0b want %0b", c, wr, exp_wr); end
            total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
            if (exp_wr) begin
                total++; if (D_in !== mkdata(owner, seq[owner])) begin bad++; $display("FAIL rand_din c%0d: got %h want %h", c, D_in, mkdata(owner, seq[owner])); end
            end
            if (owner < 0) begin
                found = 1'b0;
                if (any && (cnt + MB <= DEP)) begin
                    for (int k = 1; k <= NR; k++) begin
                        if (!found && vld[(rr + k) % NR]) begin
                            found = 1'b1;
                            owner = (rr + k) % NR;
                            gid   = owner;
                            beats = 0;
                        end
                    end
                end
            end else if (exp_wr) begin
                beats++;
                if (cl[owner] || beats == MB) begin
                    rr    = owner;
                    owner = -1;
                end
            end
            for (int r = 0; r < NR; r++) begin
                if (vld[r] && exp_ready[r]) begin
                    seq[r]++;
                    cl[r] = ($urandom_range(0, 2) == 0);
                end
            end
            cyc();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_room();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
